// File: rtl/uart_hex_byte_sender.sv
// uart_hex_byte_sender: formats one byte as two uppercase ASCII hex digits
// followed by CR LF and shifts the four characters out as 8N1 UART frames.
module uart_hex_byte_sender #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       uart_txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(PAYLOAD_BITS);
  localparam int unsigned CHAR_W = 2;

  localparam logic [CNT_W-1:0]  BAUD_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         baud_cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic [CHAR_W-1:0]        char_idx;
  logic [7:0]               data_q;
  logic [PAYLOAD_BITS-1:0]  cur_char;
  logic [BIT_W-1:0]         nxt_bit;
  logic                     bit_end;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

  // Character currently being framed, always derived from the latched byte.
  always_comb begin
    cur_char = '0;
    case (char_idx)
      2'd0:    cur_char = PAYLOAD_BITS'(hex_ascii(data_q[7:4]));
      2'd1:    cur_char = PAYLOAD_BITS'(hex_ascii(data_q[3:0]));
      2'd2:    cur_char = PAYLOAD_BITS'(8'h0D);
      default: cur_char = PAYLOAD_BITS'(8'h0A);
    endcase
  end

  // Bit-boundary strobe and next data bit index.
  always_comb begin
    bit_end = (baud_cnt == BAUD_MAX);
    nxt_bit = bit_idx + BIT_W'(1);
  end

  // Sequencer: baud timing, frame serialization and character stepping;
  // uart_txd is loaded only at bit boundaries so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      data_q   <= '0;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          uart_txd <= 1'b1;
          if (send_en) begin
            data_q   <= send_data;
            char_idx <= '0;
            bit_idx  <= '0;
            uart_txd <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= cur_char[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= nxt_bit;
              uart_txd <= cur_char[nxt_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (char_idx == LAST_CHAR) begin
              uart_txd <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              char_idx <= char_idx + CHAR_W'(1);
              uart_txd <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          uart_txd <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
